// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the debug frame scheduler.
package debug_pkg;

  localparam int SEQ_LEN    = 16;  // width of one padded debug variable
  localparam int SEQ_NUM    = 20;  // number of debug variables
  localparam int SEQ_DIGITS = 5;   // sign code + SEQ_LEN/4 hex codes
  localparam int CODE_WIDTH = 5;   // glyph code width
  localparam int TIMEOUT    = 64;  // REQ cycles to wait before giving up on an entry
  localparam int IDX_WIDTH  = 5;   // variable index width

  // Glyph codes beyond the 0-15 hex digits
  localparam int CODE_MINUS = 16;
  localparam int CODE_BLANK = 17;
  localparam int CODE_ERR   = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_GAP    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/debug_code_buf.sv
// Double-buffered glyph code store: entries are written one at a time into the
// shadow bank, the whole shadow bank is copied to the display bank in one edge,
// and the pixel generator reads the display bank combinationally.
module debug_code_buf
  import debug_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [IDX_WIDTH-1:0]             wr_idx,
  input  logic [SEQ_DIGITS*CODE_WIDTH-1:0] wr_codes,
  input  logic                             commit,
  input  logic [IDX_WIDTH-1:0]             rd_idx,
  input  logic [2:0]                       rd_digit,
  output logic [CODE_WIDTH-1:0]            rd_code
);

  localparam int ENTRY_W = SEQ_DIGITS * CODE_WIDTH;
  localparam logic [ENTRY_W-1:0] BLANK_ENTRY = {SEQ_DIGITS{CODE_WIDTH'(CODE_BLANK)}};

  logic [ENTRY_W-1:0] shadow_q  [SEQ_NUM];
  logic [ENTRY_W-1:0] display_q [SEQ_NUM];
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_idx_ok;

  genvar gi;
  generate
    for (gi = 0; gi < SEQ_NUM; gi++) begin : g_entry
      // Per-entry shadow write and bulk shadow-to-display copy; reset blanks both
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q[gi]  <= BLANK_ENTRY;
          display_q[gi] <= BLANK_ENTRY;
        end else begin
          if (wr_en && (wr_idx == IDX_WIDTH'(gi))) begin
            shadow_q[gi] <= wr_codes;
          end
          if (commit) begin
            display_q[gi] <= shadow_q[gi];
          end
        end
      end
    end
  endgenerate

  // Select the addressed display entry; out-of-range indices read as blank
  always_comb begin
    rd_entry  = BLANK_ENTRY;
    rd_idx_ok = 1'b0;
    for (int i = 0; i < SEQ_NUM; i++) begin
      if (rd_idx == IDX_WIDTH'(i)) begin
        rd_entry  = display_q[i];
        rd_idx_ok = 1'b1;
      end
    end
  end

  // Select the addressed digit; out-of-range digits read as blank
  always_comb begin
    rd_code = CODE_WIDTH'(CODE_BLANK);
    for (int d = 0; d < SEQ_DIGITS; d++) begin
      if (rd_idx_ok && (rd_digit == 3'(d))) begin
        rd_code = rd_entry[d*CODE_WIDTH +: CODE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/debug_frame_scheduler.sv
// Walks every debug variable through one shared hex/sign converter per frame,
// working from a snapshot taken at frame start, and commits the resulting glyph
// codes to the display buffer in a single edge once the sweep is complete.
module debug_frame_scheduler
  import debug_pkg::*;
(
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             enable,
  input  logic                             frame_start,
  input  logic [SEQ_NUM*SEQ_LEN-1:0]       seq_bus,
  output logic                             conv_req,
  output logic [SEQ_LEN-1:0]               conv_data,
  input  logic                             conv_ack,
  input  logic [SEQ_DIGITS*CODE_WIDTH-1:0] conv_codes,
  input  logic [IDX_WIDTH-1:0]             rd_idx,
  input  logic [2:0]                       rd_digit,
  output logic [CODE_WIDTH-1:0]            rd_code,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             conv_err,
  output logic [7:0]                       overrun_cnt
);

  localparam int WAIT_W  = $clog2(TIMEOUT) + 1;
  localparam int ENTRY_W = SEQ_DIGITS * CODE_WIDTH;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [SEQ_LEN-1:0]   snap_q [SEQ_NUM];
  logic                 conv_err_q;
  logic [7:0]           overrun_q;

  logic                 start_sweep;
  logic                 last_entry;
  logic                 timeout_hit;
  logic                 entry_done;
  logic                 commit_en;
  logic [ENTRY_W-1:0]   err_codes;
  logic [ENTRY_W-1:0]   wr_codes;

  assign start_sweep = (state_q == ST_IDLE) && frame_start && enable;
  assign last_entry  = (idx_q == IDX_WIDTH'(SEQ_NUM - 1));
  // An ack in the final wait cycle wins over the timeout
  assign timeout_hit = (state_q == ST_REQ) && !conv_ack && (wait_q == WAIT_W'(TIMEOUT - 1));
  assign entry_done  = (state_q == ST_REQ) && (conv_ack || timeout_hit);
  assign commit_en   = (state_q == ST_COMMIT);

  // Timeout error entry: 'E' in the sign position, blanks elsewhere
  genvar gi;
  generate
    for (gi = 0; gi < SEQ_DIGITS; gi++) begin : g_err
      assign err_codes[gi*CODE_WIDTH +: CODE_WIDTH] =
        (gi == 0) ? CODE_WIDTH'(CODE_ERR) : CODE_WIDTH'(CODE_BLANK);
    end
  endgenerate

  assign wr_codes = conv_ack ? conv_codes : err_codes;

  // State, index and wait-counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic for the sweep sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_sweep) begin
          state_d = ST_REQ;
          idx_d   = '0;
        end
      end
      ST_REQ: begin
        if (entry_done) begin
          if (last_entry) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_GAP;
            idx_d   = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_GAP:    state_d = ST_REQ;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    conv_req   = 1'b0;
    conv_data  = '0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_REQ: begin
        conv_req  = 1'b1;
        conv_data = snap_q[idx_q];
        busy      = 1'b1;
      end
      ST_GAP: busy = 1'b1;
      ST_COMMIT: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  generate
    for (gi = 0; gi < SEQ_NUM; gi++) begin : g_snap
      // Atomic snapshot of every variable on the edge that starts a sweep
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          snap_q[gi] <= '0;
        end else if (start_sweep) begin
          snap_q[gi] <= seq_bus[gi*SEQ_LEN +: SEQ_LEN];
        end
      end
    end
  endgenerate

  // Sticky converter-timeout flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      conv_err_q <= 1'b0;
    end else if (timeout_hit) begin
      conv_err_q <= 1'b1;
    end
  end

  // Saturating count of enabled frame_start pulses that arrive mid-sweep
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overrun_q <= '0;
    end else if (frame_start && enable && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign conv_err    = conv_err_q;
  assign overrun_cnt = overrun_q;

  debug_code_buf u_code_buf (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .wr_en    (entry_done),
    .wr_idx   (idx_q),
    .wr_codes (wr_codes),
    .commit   (commit_en),
    .rd_idx   (rd_idx),
    .rd_digit (rd_digit),
    .rd_code  (rd_code)
  );

endmodule

// File: tb/tb_debug_frame_scheduler.sv
// Bench for debug_frame_scheduler: a converter model on the handshake, a
// schedule-based reference model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_debug_frame_scheduler;
  import debug_pkg::*;

  localparam int N  = SEQ_NUM;
  localparam int D  = SEQ_DIGITS;
  localparam int TO = TIMEOUT;
  localparam logic [15:0] DEAD = 16'hDEAD;  // converter never acks this value
  localparam logic [24:0] BLANK25 = {5{5'd17}};
  localparam logic [24:0] ERR25   = {{4{5'd17}}, 5'd18};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          frame_start;
  logic [N*16-1:0] seq_bus;
  logic          conv_req;
  logic [15:0]   conv_data;
  logic          conv_ack;
  logic [24:0]   conv_codes;
  logic [4:0]    rd_idx;
  logic [2:0]    rd_digit;
  logic [4:0]    rd_code;
  logic          busy;
  logic          frame_done;
  logic          conv_err;
  logic [7:0]    overrun_cnt;

  debug_frame_scheduler dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .seq_bus     (seq_bus),
    .conv_req    (conv_req),
    .conv_data   (conv_data),
    .conv_ack    (conv_ack),
    .conv_codes  (conv_codes),
    .rd_idx      (rd_idx),
    .rd_digit    (rd_digit),
    .rd_code     (rd_code),
    .busy        (busy),
    .frame_done  (frame_done),
    .conv_err    (conv_err),
    .overrun_cnt (overrun_cnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Converter: sign glyph then four hex digits of the magnitude, MS first
  function automatic logic [24:0] hexsign(input logic [15:0] v);
    logic [15:0] m;
    logic [24:0] r;
    m = v[15] ? (16'd0 - v) : v;
    r[4:0] = v[15] ? 5'd16 : 5'd17;
    for (int k = 1; k <= 4; k++) r[k*5 +: 5] = {1'b0, m[(4-k)*4 +: 4]};
    return r;
  endfunction

  // Ack arrives in REQ cycle number ack_dly (0 = first cycle), never for DEAD
  int ack_dly = 0;
  int req_cnt = 0;
  always @(posedge clk) req_cnt <= conv_req ? req_cnt + 1 : 0;
  assign conv_ack   = conv_req && (conv_data != DEAD) && (req_cnt == ack_dly);
  assign conv_codes = hexsign(conv_data);

  // Reference model: a sweep is a precomputed schedule of REQ windows
  logic [24:0] disp_m [N];
  logic [24:0] shad_m [N];
  logic [15:0] snap_m [N];
  int          req_s  [N];
  int          req_e  [N];
  bit          to_m   [N];
  int          commit_c = 0;
  bit          active = 1'b0;
  bit          err_m = 1'b0;
  int          ovr_m = 0;

  always @(negedge clk) begin
    int ri;
    int rexp;
    int t;
    bit busy_m;
    logic [24:0] e;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        disp_m[i] = BLANK25;
        shad_m[i] = BLANK25;
      end
      active = 1'b0;
      err_m  = 1'b0;
      ovr_m  = 0;
    end
    ri = -1;
    if (active) begin
      for (int i = 0; i < N; i++) if (cyc >= req_s[i] && cyc <= req_e[i]) ri = i;
    end
    busy_m = active && (cyc >= req_s[0]) && (cyc <= commit_c);
    rexp = 17;
    if (rd_idx < 5'(N) && rd_digit < 3'(D)) begin
      e = disp_m[rd_idx];
      rexp = int'(e[rd_digit*5 +: 5]);
    end
    chk("conv_req", int'(conv_req), (ri >= 0) ? 1 : 0);
    chk("conv_data", int'(conv_data), (ri >= 0) ? int'(snap_m[ri]) : 0);
    chk("busy", int'(busy), int'(busy_m));
    chk("frame_done", int'(frame_done), (active && cyc == commit_c) ? 1 : 0);
    chk("conv_err", int'(conv_err), int'(err_m));
    chk("overrun_cnt", int'(overrun_cnt), ovr_m);
    chk("rd_code", int'(rd_code), rexp);
    if (rst_n) begin
      if (ri >= 0 && cyc == req_e[ri]) begin
        shad_m[ri] = to_m[ri] ? ERR25 : hexsign(snap_m[ri]);
        if (to_m[ri]) err_m = 1'b1;
      end
      if (active && cyc == commit_c) begin
        for (int i = 0; i < N; i++) disp_m[i] = shad_m[i];
        active = 1'b0;
      end
      if (frame_start && enable) begin
        if (busy_m) begin
          ovr_m = (ovr_m < 255) ? ovr_m + 1 : 255;
        end else if (!active) begin
          t = cyc + 1;
          for (int i = 0; i < N; i++) begin
            snap_m[i] = seq_bus[i*16 +: 16];
            to_m[i]   = (snap_m[i] == DEAD) || (ack_dly >= TO);
            req_s[i]  = t;
            req_e[i]  = t + (to_m[i] ? TO : ack_dly + 1) - 1;
            t         = req_e[i] + 2;
          end
          commit_c = req_e[N-1] + 1;
          active   = 1'b1;
        end
      end
    end
  end

  // Stimulus helpers; rd port scans all indices (including out of range) by default
  int scan = 0;
  task automatic step();
    @(posedge clk);
    #1;
    rd_idx   = 5'(scan % 23);
    rd_digit = 3'((scan / 23) % 8);
    scan++;
  endtask

  task automatic peek(input string nm, input int idx, input int dig, input int exp);
    rd_idx   = 5'(idx);
    rd_digit = 3'(dig);
    #1;
    chk(nm, int'(rd_code), exp);
  endtask

  task automatic set_entry(input int i, input logic [15:0] v);
    seq_bus[i*16 +: 16] = v;
  endtask

  task automatic pulse(output int fs);
    step();
    frame_start = 1'b1;
    fs = cyc;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  int fs;
  int t;

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; seq_bus = '0;
    rd_idx = '0; rd_digit = '0;
    repeat (3) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_req", int'(conv_req), 0);
    chk("reset_ovr", int'(overrun_cnt), 0);
    peek("reset_rd", 3, 2, 17);
    rst_n = 1'b1;
    step();

    // Zero-wait converter
    for (int i = 0; i < N; i++) set_entry(i, 16'(i * 16'h0731 + 16'h0100));
    set_entry(0, 16'hFFFF);
    set_entry(1, 16'h0012);
    enable = 1'b1; ack_dly = 0;
    pulse(fs);
    repeat (5) step();
    peek("precommit_rd", 0, 0, 17);
    wait_done("zw", 200, t);
    chk("zw_done_cycle", t - fs, 40);
    step();
    chk("zw_busy_after", int'(busy), 0);
    peek("zw_e0_d0", 0, 0, 16); peek("zw_e0_d1", 0, 1, 0); peek("zw_e0_d4", 0, 4, 1);
    peek("zw_e1_d0", 1, 0, 17); peek("zw_e1_d3", 1, 3, 1); peek("zw_e1_d4", 1, 4, 2);
    peek("zw_idx_oob", 20, 0, 17);
    peek("zw_digit_oob", 0, 5, 17);

    // Ack in the third REQ cycle: 3 REQ + 1 GAP per entry, last entry REQ 77..79
    ack_dly = 2;
    pulse(fs);
    wait_done("slow", 300, t);
    chk("slow_done_cycle", t - fs, 80);

    // Entry 5 never acked: entry 5 REQ 11..74, entry 19 REQ at 102, commit 103
    ack_dly = 0;
    set_entry(5, DEAD);
    pulse(fs);
    wait_done("tmo", 300, t);
    chk("tmo_done_cycle", t - fs, 103);
    chk("tmo_err", int'(conv_err), 1);
    step();
    peek("tmo_e5_d0", 5, 0, 18); peek("tmo_e5_d1", 5, 1, 17);
    peek("tmo_e6_d0", 6, 0, int'(hexsign(16'(6 * 16'h0731 + 16'h0100)) & 25'h1F));
    set_entry(5, 16'h0005);
    pulse(fs);
    wait_done("tmo2", 200, t);
    chk("tmo2_done_cycle", t - fs, 40);
    chk("tmo2_err_sticky", int'(conv_err), 1);
    step();
    peek("tmo2_e5_d4", 5, 4, 5); peek("tmo2_e5_d0", 5, 0, 17);

    // Overrun: second pulse mid-sweep dropped, snapshot unaffected by bus change
    pulse(fs);
    repeat (4) step();
    set_entry(0, 16'h1234);
    repeat (5) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_done("ovr", 200, t);
    chk("ovr_done_cycle", t - fs, 40);
    chk("ovr_count", int'(overrun_cnt), 1);
    step();
    peek("ovr_e0_d0", 0, 0, 16); peek("ovr_e0_d4", 0, 4, 1);

    // enable low: pulse ignored entirely
    enable = 1'b0;
    pulse(fs);
    repeat (10) step();
    chk("dis_busy", int'(busy), 0);
    chk("dis_ovr", int'(overrun_cnt), 1);
    peek("dis_hold", 0, 0, 16);
    // enable dropped mid-sweep: sweep still completes
    enable = 1'b1;
    pulse(fs);
    repeat (4) step();
    enable = 1'b0;
    wait_done("dis2", 200, t);
    chk("dis2_done_cycle", t - fs, 40);
    step();
    peek("dis2_e0_d0", 0, 0, 17); peek("dis2_e0_d1", 0, 1, 1); peek("dis2_e0_d4", 0, 4, 4);

    // Reset mid-sweep
    enable = 1'b1;
    pulse(fs);
    repeat (19) step();
    rst_n = 1'b0;
    step();
    step();
    chk("mrst_req", int'(conv_req), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_err", int'(conv_err), 0);
    chk("mrst_ovr", int'(overrun_cnt), 0);
    chk("mrst_data", int'(conv_data), 0);
    for (int i = 0; i < N; i++) begin
      step();
      for (int d = 0; d < D; d++) peek("mrst_blank", i, d, 17);
    end
    rst_n = 1'b1;
    step();
    chk("mrst_release_req", int'(conv_req), 0);
    pulse(fs);
    chk("mrst_restart_req", int'(conv_req), 1);
    chk("mrst_restart_data", int'(conv_data), 16'h1234);
    wait_done("mrst", 200, t);
    chk("mrst_done_cycle", t - fs, 40);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
